// File: rtl/memory_arbiter.sv
// Two-port (instruction/data) arbiter onto a single-cycle storage port with one registered response slot.
// Define MEMORY_ARBITER_ROUND_ROBIN_EN for alternating priority on contention; default build gives the data port priority.
module memory_arbiter #(
   parameter int ADRESS_SIZE = 32,
   parameter int BIT_COUNT   = 32
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     IReqValid,
   output logic                     IReqReady,
   input  logic [ADRESS_SIZE-1:0]   IReqAdress,
   input  logic                     DReqValid,
   output logic                     DReqReady,
   input  logic                     DReqWrite,
   input  logic [BIT_COUNT/8-1:0]   DReqByteEn,
   input  logic [ADRESS_SIZE-1:0]   DReqAdress,
   input  logic [BIT_COUNT-1:0]     DReqData,
   output logic                     RspValid,
   output logic                     RspPort,
   output logic [BIT_COUNT-1:0]     RspData,
   input  logic                     RspReady,
   output logic                     MemEn,
   output logic                     MemWriteEn,
   output logic [BIT_COUNT/8-1:0]   MemByteEn,
   output logic [ADRESS_SIZE-1:0]   MemAdress,
   output logic [BIT_COUNT-1:0]     MemWriteData,
   input  logic [BIT_COUNT-1:0]     MemReadData
);
   localparam int BE_W = BIT_COUNT / 8;

   typedef enum logic {IDLE = 1'b0, HOLD = 1'b1} state_t;

   state_t               state_q, state_d;
   logic                 rsp_valid_q, rsp_valid_d;
   logic                 rsp_port_q, rsp_port_d;
   logic [BIT_COUNT-1:0] rsp_data_q, rsp_data_d;
   logic                 grant, any_req, sel_d, accept;

   // A new access may start whenever the response slot is empty or being drained this cycle.
   assign grant   = (state_q == IDLE) || RspReady;
   assign any_req = IReqValid || DReqValid;
   assign accept  = grant && any_req;

`ifdef MEMORY_ARBITER_ROUND_ROBIN_EN
   logic last_d_q, last_d_d;
   assign sel_d = DReqValid && !(IReqValid && last_d_q);
`else
   assign sel_d = DReqValid;
`endif

   assign IReqReady    = accept && !sel_d;
   assign DReqReady    = accept && sel_d;
   assign MemEn        = accept;
   assign MemWriteEn   = accept && sel_d && DReqWrite;
   assign MemAdress    = sel_d ? DReqAdress : IReqAdress;
   assign MemWriteData = sel_d ? DReqData : '0;
   assign MemByteEn    = !accept ? {BE_W{1'b0}} : (MemWriteEn ? DReqByteEn : {BE_W{1'b1}});

   assign RspValid = rsp_valid_q;
   assign RspPort  = rsp_port_q;
   assign RspData  = rsp_data_q;

   always_comb begin
      state_d     = state_q;
      rsp_valid_d = rsp_valid_q;
      rsp_port_d  = rsp_port_q;
      rsp_data_d  = rsp_data_q;
`ifdef MEMORY_ARBITER_ROUND_ROBIN_EN
      last_d_d    = last_d_q;
`endif
      if (accept) begin
         state_d     = HOLD;
         rsp_valid_d = 1'b1;
         rsp_port_d  = sel_d;
         rsp_data_d  = MemWriteEn ? {BIT_COUNT{1'b0}} : MemReadData;
`ifdef MEMORY_ARBITER_ROUND_ROBIN_EN
         last_d_d    = sel_d;
`endif
      end else if (grant) begin
         state_d     = IDLE;
         rsp_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= IDLE;
         rsp_valid_q <= 1'b0;
         rsp_port_q  <= 1'b0;
         rsp_data_q  <= '0;
`ifdef MEMORY_ARBITER_ROUND_ROBIN_EN
         last_d_q    <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_port_q  <= rsp_port_d;
         rsp_data_q  <= rsp_data_d;
`ifdef MEMORY_ARBITER_ROUND_ROBIN_EN
         last_d_q    <= last_d_d;
`endif
      end
   end

endmodule

// File: doc/memory_arbiter.md
MEMORY_ARBITER -- requirements
Module: memory_arbiter

Interface
REQ-001 Parameter ADRESS_SIZE, default 32, byte-address width on all address ports.
REQ-002 Parameter BIT_COUNT, default 32, data word width; BIT_COUNT/8 byte lanes.
REQ-003 clk  input  1  single clock; all state on rising edge.
REQ-004 reset  input  1  asynchronous, active-low (asserted when 0).
REQ-005 IReqValid  input  1  instruction-port read request.
REQ-006 IReqReady  output  1  instruction request accepted this cycle.
REQ-007 IReqAdress  input  ADRESS_SIZE  instruction byte address.
REQ-008 DReqValid  input  1  data-port request.
REQ-009 DReqReady  output  1  data request accepted this cycle.
REQ-010 DReqWrite  input  1  1 = write, 0 = read.
REQ-011 DReqByteEn  input  BIT_COUNT/8  write byte lanes; ignored on reads.
REQ-012 DReqAdress  input  ADRESS_SIZE  data byte address.
REQ-013 DReqData  input  BIT_COUNT  write data.
REQ-014 RspValid  output  1  response held in output register.
REQ-015 RspPort  output  1  0 = instruction, 1 = data owner of response.
REQ-016 RspData  output  BIT_COUNT  read data; 0 for write responses.
REQ-017 RspReady  input  1  response consumed this cycle.
REQ-018 MemEn, MemWriteEn  output  1 each  storage enable / write enable.
REQ-019 MemByteEn  output  BIT_COUNT/8  storage byte enables.
REQ-020 MemAdress, MemWriteData  output  ADRESS_SIZE / BIT_COUNT  storage address and write data, passed unmodified (storage does word shift).
REQ-021 MemReadData  input  BIT_COUNT  combinational storage read data.

Function
REQ-022 FSM states IDLE (response register empty) and HOLD (RspValid=1).
REQ-023 Grant cycle: state IDLE, or HOLD with RspReady=1; otherwise no grant, both Ready outputs 0.
REQ-024 In a grant cycle with any valid request, exactly one requester gets Ready=1 (combinational); winner per REQ-034/035.
REQ-025 Grant cycle drives MemEn=1, MemAdress/MemWriteData/MemByteEn from winner; MemWriteEn=1 only for data winner with DReqWrite=1.
REQ-026 Non-grant cycles: MemEn=0, MemWriteEn=0, MemByteEn=0.
REQ-027 Latency 1: edge ending grant cycle loads RspData (MemReadData, or 0 for write), RspPort, RspValid=1; state HOLD.
REQ-028 HOLD with RspReady=1 and no request: RspValid=0 next cycle, state IDLE.
REQ-029 HOLD with RspReady=0: RspValid, RspPort, RspData stable; no grant.
REQ-030 HOLD with RspReady=1 and request: back-to-back grant; throughput one access per cycle.
REQ-031 Write with DReqByteEn=0: still granted and responded; storage word unchanged.
REQ-032 No alignment check; address bits [1:0] passed through.

Reset
REQ-033 reset=0 immediately forces state IDLE, RspValid=0, RspPort=0, RspData=0, priority pointer=0; in-flight response discarded, write committed at a prior edge stays committed.

Configuration
REQ-034 Macro MEMORY_ARBITER_ROUND_ROBIN_EN undefined: fixed priority, data port wins when both valid.
REQ-035 Macro defined: one-bit pointer holds last winner; on contention the other port wins; pointer updates every grant; single requester always wins.

Verification
REQ-036 Reset, IReqValid=1 addr 0x8 -> IReqReady=1 cycle 1, MemEn=1, RspValid=1 RspPort=0 RspData=mem[2] cycle 2.
REQ-037 Data write 0x4, ByteEn=4'b0011, data 0xAABBCCDD over 0x11223344 -> MemWriteEn=1; later read 0x4 gives 0x1122CCDD.
REQ-038 Both valid 4 cycles, RspReady=1: fixed build D,D,D,D; round-robin build D,I,D,I.
REQ-039 RspReady=0 for 3 cycles in HOLD -> Rsp outputs stable, IReqReady=DReqReady=0, MemEn=0.
REQ-040 reset=0 mid-HOLD between edges -> RspValid=0 immediately; after release next grant to D on contention.
